pcihellocore_button_pio_in: RTL and testbench
=============================================

// Module: pcihellocore_button_pio_in
// PURPOSE
//  Avalon-MM slave input port: samples external buttons/switches, debounces per bit, exposes the value for CPU/PCI reads.
//  Latches configurable edges into a sticky capture register and raises a maskable level IRQ.
//  Sits beside the LED output PIOs on the same Avalon interconnect and uses the same register access timing.
// PARAMETERS
//  WIDTH            16     number of input bits (1..32)
//  DEBOUNCE_CYCLES  50000  consecutive clk cycles an input must differ before it is accepted (>=1; 1 = no filtering)
//  EDGE_TYPE        0      edges captured: 0 rising, 1 falling, 2 any
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous active-low reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  in_port     in   WIDTH  raw asynchronous inputs
//  readdata    out  32     read data, zero-extended
//  irq         out  1      level interrupt request
// BEHAVIOUR
//  Register map (address):
//   0 DATA  RO  debounced value db[WIDTH-1:0]; writes ignored
//   1 RSVD  reads 0, writes ignored
//   2 MASK  RW  irq_mask[WIDTH-1:0]
//   3 EDGE  R/W1C  edge_cap[WIDTH-1:0]
//  Reads: combinational, zero wait state; readdata = selected register, upper bits 0.
//   readdata is not gated by chipselect. Reads have no side effects.
//  Writes: take effect on the clk edge where chipselect=1 and write_n=0.
//  Input path: 2-flop synchronizer per bit gives sync[i]. Changes on in_port are visible in sync 2 clks later.
//  Debounce: one counter per bit, width clog2(DEBOUNCE_CYCLES) (min 1). Each clk:
//   - sync==db: cnt<=0.
//   - sync!=db and cnt==DEBOUNCE_CYCLES-1: db<=sync, cnt<=0.
//   - otherwise: cnt<=cnt+1.
//   - Result: db updates on the DEBOUNCE_CYCLES-th consecutive differing cycle.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles resets the count and never reaches db.
//  Edge capture: edge_cap[i] is set on the same clk edge db[i] changes, if the change matches EDGE_TYPE.
//   - Bits are sticky until cleared by writing 1 to that bit at address 3.
//   - Writing 0 to a bit has no effect.
//   - Simultaneous set and clear of the same bit: set wins (bit stays 1).
//  irq = |(edge_cap & irq_mask), combinational from registers.
//   - Masking a pending bit drops irq but keeps edge_cap.
//   - Unmasking a pending bit raises irq immediately.
//  Reset (async, any time, including mid-debounce): sync, db, cnt, irq_mask, edge_cap <= 0.
//   - Outputs after reset: readdata=0 for all addresses, irq=0.
//   - An input held high through reset is accepted as a normal 0->1 change after release.
//   - With EDGE_TYPE 0 or 2, that change sets edge_cap.
//  writedata bits above WIDTH are ignored; reads of those bits return 0.
// TESTING (WIDTH=16, DEBOUNCE_CYCLES=4 unless stated)
//  1. Debounce latency: reset, then in_port 0x0000->0x0001 held.
//     -> DATA reads 0x0001 exactly 2+4 clks after the in_port sample edge.
//     -> EDGE=0x0001.
//  2. Glitch rejection: in_port[3] high for 3 clks, then low.
//     -> DATA and EDGE stay 0 throughout.
//     Follow with 4 clks high -> DATA bit 3 set.
//  3. IRQ masking, EDGE_TYPE=0: write MASK=0x0000, produce a rising edge on bit 5.
//     -> EDGE=0x0020, irq=0.
//     Write MASK=0x0020 -> irq=1 the next cycle.
//     Write EDGE=0x0020 -> EDGE=0, irq=0.
//  4. Clear/set collision: time a W1C write of 0x0001 to the same edge that db[0] rises.
//     -> EDGE bit 0 remains 1, irq stays asserted.
//  5. EDGE_TYPE=1 and EDGE_TYPE=2 builds: toggle bit 0 up then down.
//     -> EDGE_TYPE=1 sets edge_cap only on the fall; EDGE_TYPE=2 sets it on both.
//  6. Reset mid-debounce: assert reset_n=0 after 2 differing cycles.
//     -> All reads 0 and irq=0 immediately.
//     After release -> debounce restarts from a count of 0.

Source files
------------

// File: rtl/pcihellocore_button_pio_in.sv
// pcihellocore_button_pio_in
//   Avalon-MM slave input port for buttons/switches. Each input bit is
//   synchronized, debounced and exposed for reads. Selected edges of the
//   debounced value are latched into a sticky capture register, which drives
//   a maskable level interrupt.
//
//   Bus handshake: this is a zero-wait-state Avalon slave. There is no
//   waitrequest. A write is accepted on the clk edge where chipselect=1 and
//   write_n=0. readdata always shows the register selected by address,
//   independent of chipselect. Reads have no side effects.
//
//   Register map (address):
//     0 DATA  RO     debounced value
//     1 RSVD         reads 0
//     2 MASK  RW     irq mask
//     3 EDGE  R/W1C  sticky edge capture (a new edge beats a same-cycle clear)
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   address    in   [1:0] register select
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   [31:0] write data (bits above WIDTH ignored)
//   in_port    in   [WIDTH-1:0] raw asynchronous inputs
//   readdata   out  [31:0] read data, zero-extended
//   irq        out  level interrupt, |(edge_cap & irq_mask)
module pcihellocore_button_pio_in #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;

  logic [CNT_W-1:0] w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused;

  assign w_wr     = chipselect && !write_n;
  // Upper writedata bits are intentionally ignored when WIDTH < 32.
  assign w_unused = ^writedata;

  // Per-bit debounce: a bit must disagree with db for DEBOUNCE_CYCLES
  // consecutive cycles; any agreeing cycle restarts the count.
  always_comb begin
    w_chg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_db[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_chg[i] = 1'b1;
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_rise = w_chg & ~r_db;
  assign w_fall = w_chg &  r_db;
  assign w_set  = (EDGE_TYPE == 0) ? w_rise :
                  (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);
  assign w_clr  = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_db    <= r_db ^ w_chg;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      if (w_wr && address == 2'd2) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      // Set is applied after clear so a coincident edge survives the W1C.
      r_edge <= (r_edge & ~w_clr) | w_set;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = 32'(r_db);
      2'd2:    readdata = 32'(r_mask);
      2'd3:    readdata = 32'(r_edge);
      default: readdata = 32'd0;
    endcase
  end

  assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_pcihellocore_button_pio_in.sv
module tb_pcihellocore_button_pio_in;

  localparam int W = 16;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = 32'd0;
  logic [W-1:0] in_port = '0;
  logic [31:0]  rd [3];
  logic         irq [3];

  // Three builds, one per EDGE_TYPE, sharing all inputs.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pcihellocore_button_pio_in #(
      .WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(g)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .in_port(in_port), .readdata(rd[g]), .irq(irq[g])
    );
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // db flips when the last N post-synchronizer samples all disagree with it.
  logic [W-1:0] m_dly [$];   // in_port delay line (two stages)
  logic [W-1:0] m_hist [$];  // last N synchronized samples
  logic [W-1:0] m_db, m_mask;
  logic [W-1:0] m_edge [3];

  task automatic model_reset();
    m_dly.delete();  m_dly.push_back('0);  m_dly.push_back('0);
    m_hist.delete();
    for (int j = 0; j < N; j++) m_hist.push_back('0);
    m_db = '0; m_mask = '0;
    for (int t = 0; t < 3; t++) m_edge[t] = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] sync_now, chg, rise, fall, clr;
    logic differ;
    sync_now = m_dly[0];
    m_hist.push_back(sync_now);
    if (m_hist.size() > N) void'(m_hist.pop_front());
    chg = '0;
    for (int i = 0; i < W; i++) begin
      differ = 1'b1;
      for (int j = 0; j < m_hist.size(); j++)
        if (m_hist[j][i] == m_db[i]) differ = 1'b0;
      chg[i] = differ;
    end
    rise = chg & ~m_db;
    fall = chg & m_db;
    clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_edge[0] = (m_edge[0] & ~clr) | rise;
    m_edge[1] = (m_edge[1] & ~clr) | fall;
    m_edge[2] = (m_edge[2] & ~clr) | rise | fall;
    m_db = m_db ^ chg;
    void'(m_dly.pop_front());
    m_dly.push_back(in_port);
  endtask

  function automatic logic [31:0] exp_read(input int t, input logic [1:0] a);
    case (a)
      2'd0:    return {16'd0, m_db};
      2'd2:    return {16'd0, m_mask};
      2'd3:    return {16'd0, m_edge[t]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    for (int t = 0; t < 3; t++) begin
      check($sformatf("%s_rd%0d_a%0d", tag, t, address), rd[t], exp_read(t, address));
      check($sformatf("%s_irq%0d", tag, t), {31'd0, irq[t]}, {31'd0, |(m_edge[t] & m_mask)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step("wr");
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check_outputs(tag);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 model_reset();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #0.5;
      for (int t = 0; t < 3; t++) check($sformatf("%s_zero%0d", tag, t), rd[t], 32'd0);
    end
    check_outputs(tag);
    @(negedge clk) reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    model_reset();
    #12;
    read_all("reset");
    check("reset_irq", {31'd0, irq[0]}, 32'd0);
    reset_n = 1'b1;

    // 1: debounce latency
    address = 2'd0;
    in_port = 16'h0001;
    steps(5, "t1");
    check("t1_early", rd[0], 32'h0);
    step("t1");
    check("t1_data", rd[0], 32'h1);
    address = 2'd3; #1;
    check("t1_edge", rd[0], 32'h1);

    // 2: glitch rejection then a real press
    address = 2'd0;
    in_port[3] = 1'b1; steps(3, "t2");
    in_port[3] = 1'b0; steps(6, "t2");
    check("t2_glitch_data", rd[0], 32'h1);
    in_port[3] = 1'b1; steps(8, "t2");
    check("t2_press_data", rd[0], 32'h9);

    // 3: irq masking
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'h0);
    in_port[5] = 1'b1; steps(8, "t3");
    address = 2'd3; #1;
    check("t3_edge", rd[0], 32'h20);
    check("t3_irq_masked", {31'd0, irq[0]}, 32'd0);
    wr(2'd2, 32'h20);
    check("t3_irq_unmasked", {31'd0, irq[0]}, 32'd1);
    wr(2'd3, 32'h20);
    check("t3_edge_clr", rd[0], 32'h0);
    check("t3_irq_clr", {31'd0, irq[0]}, 32'd0);

    // 4: clear/set collision on bit 0
    wr(2'd2, 32'h1);
    in_port[0] = 1'b0; steps(8, "t4");
    in_port[0] = 1'b1; steps(5, "t4");
    wr(2'd3, 32'h1);
    check("t4_edge", rd[0], 32'h1);
    check("t4_irq", {31'd0, irq[0]}, 32'd1);

    // 5: falling / any edge builds
    wr(2'd3, 32'hFFFF);
    in_port[0] = 1'b0; steps(8, "t5");
    address = 2'd3; #1;
    check("t5_fall_e0", rd[0], 32'h0);
    check("t5_fall_e1", rd[1], 32'h1);
    check("t5_fall_e2", rd[2], 32'h1);
    wr(2'd3, 32'hFFFF);
    in_port[0] = 1'b1; steps(8, "t5");
    check("t5_rise_e0", rd[0], 32'h1);
    check("t5_rise_e1", rd[1], 32'h0);
    check("t5_rise_e2", rd[2], 32'h1);

    // 6: reset mid-debounce
    in_port = 16'hFFFF;
    steps(4, "t6");
    async_reset("t6");
    address = 2'd0;
    steps(5, "t6");
    check("t6_early", rd[0], 32'h0);
    step("t6");
    check("t6_data", rd[0], 32'hFFFF);
    address = 2'd3; #1;
    check("t6_edge", rd[0], 32'hFFFF);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      chipselect = 1'b0; write_n = 1'b1;
      r = $urandom_range(0, 99);
      if (r < 8)       in_port[$urandom_range(0, W-1)] ^= 1'b1;
      else if (r < 14) in_port[$urandom_range(0, 3)]   ^= 1'b1;
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom;
      r = $urandom_range(0, 99);
      if (r < 12) begin
        chipselect = 1'b1; write_n = 1'b0;
      end else if (r < 16) begin
        chipselect = 1'b0; write_n = 1'b0;
      end
      step("rnd");
      if ($urandom_range(0, 999) == 0) async_reset("rnd_rst");
    end
    chipselect = 1'b0; write_n = 1'b1;
    read_all("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
